// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_write_arbiter_pkg;

    // Default address/data widths of the register-file write port.
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    // Index of the hard-wired zero register; writes to it are no-ops.
    localparam int REG_ZERO_IDX = 0;

    // Starvation tracker: IDLE = buffer empty, WAIT = head waiting for a
    // free slot, FORCE = one-cycle pipeline stall that drains the head.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rf_write_arbiter_fifo.sv
// DEPTH-entry FIFO of MDU results. Each entry carries a valid bit so that a
// younger pipeline write to the same register can cancel it in place; a
// cancelled entry still occupies its slot until it reaches the head.
module mdu_result_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_deq,
    input  logic          i_kill_en,
    input  logic [AW-1:0] i_kill_addr,
    input  logic [AW-1:0] i_chk_addr,
    output logic          o_chk_match,
    output logic          o_head_valid,
    output logic [AW-1:0] o_head_addr,
    output logic [DW-1:0] o_head_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;

    // Storage update: kill matching entries, retire the head, append new entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && r_vld[i] && (r_addr[i] == i_kill_addr)) begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (i_deq) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            if (i_push) begin
                r_vld[r_wr_ptr]  <= 1'b1;
                r_addr[r_wr_ptr] <= i_push_addr;
                r_data[r_wr_ptr] <= i_push_data;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + CW'(i_push) - CW'(i_deq);
        end
    end

    // Hazard query: any still-valid entry targeting the queried register.
    always_comb begin
        o_chk_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == i_chk_addr)) begin
                o_chk_match = 1'b1;
            end
        end
    end

    assign o_head_valid = r_vld[r_rd_ptr];
    assign o_head_addr  = r_addr[r_rd_ptr];
    assign o_head_data  = r_data[r_rd_ptr];
    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == CW'(DEPTH));
    assign o_count      = r_count;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline write-back (always
// first) and buffered MDU results, which drain into idle slots. A head entry
// left waiting STARVE_LIMIT cycles triggers a one-cycle pipeline stall.
//
// MDU handshake: a result transfers on a rising edge where mdu_valid and
// mdu_ready are both 1; mdu_ready depends only on buffer occupancy (never on
// mdu_valid), and a full buffer stays not-ready even in a cycle it pops.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_writereg,
    input  logic [DW-1:0] wb_writedata,
    input  logic          mdu_valid,
    output logic          mdu_ready,
    input  logic [AW-1:0] mdu_writereg,
    input  logic [DW-1:0] mdu_writedata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          pipe_stall,
    input  logic [AW-1:0] chk_reg,
    output logic          chk_pending,
    output arb_state_t    dbg_state
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [AW-1:0] R0 = AW'(REG_ZERO_IDX);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic [SW-1:0] r_starve;
    logic [SW-1:0] w_starve_next;

    logic          w_wb_eff;
    logic          w_push;
    logic          w_head_pop;
    logic          w_skip;
    logic          w_deq;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic          w_head_valid;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic          w_chk_match;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_empty_next;

    // A forced-drain cycle ignores write-back; r0 writes never occupy the port.
    assign w_wb_eff     = wb_regwrite && (wb_writereg != R0) && (r_state != ST_FORCE);
    assign w_push       = mdu_valid && !w_fifo_full && (mdu_writereg != R0);
    assign w_skip       = !w_fifo_empty && !w_head_valid;
    assign w_head_pop   = !w_fifo_empty && w_head_valid && !w_wb_eff;
    assign w_deq        = w_skip || w_head_pop;
    assign w_count_next = w_count + CW'(w_push) - CW'(w_deq);
    assign w_empty_next = (w_count_next == '0);

    assign mdu_ready    = !w_fifo_full;
    assign chk_pending  = w_chk_match && (chk_reg != R0);

    mdu_result_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .CW    (CW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_addr  (mdu_writereg),
        .i_push_data  (mdu_writedata),
        .i_deq        (w_deq),
        .i_kill_en    (w_wb_eff),
        .i_kill_addr  (wb_writereg),
        .i_chk_addr   (chk_reg),
        .o_chk_match  (w_chk_match),
        .o_head_valid (w_head_valid),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_empty      (w_fifo_empty),
        .o_full       (w_fifo_full),
        .o_count      (w_count)
    );

    // Registered write port: write-back first, else the valid buffer head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (w_wb_eff) begin
            rf_we    <= 1'b1;
            rf_waddr <= wb_writereg;
            rf_wdata <= wb_writedata;
        end else if (w_head_pop) begin
            rf_we    <= 1'b1;
            rf_waddr <= w_head_addr;
            rf_wdata <= w_head_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Starvation state register and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_next;
            r_starve <= w_starve_next;
        end
    end

    // Starvation next state: count un-popped head cycles, force at the limit.
    always_comb begin
        w_state_next  = r_state;
        w_starve_next = r_starve;
        if (w_empty_next) begin
            w_state_next  = ST_IDLE;
            w_starve_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next  = ST_WAIT;
                    w_starve_next = '0;
                end
                ST_WAIT: begin
                    if (w_deq) begin
                        w_starve_next = '0;
                    end else if (r_starve == SW'(STARVE_LIMIT - 1)) begin
                        w_state_next  = ST_FORCE;
                        w_starve_next = '0;
                    end else begin
                        w_starve_next = r_starve + 1'b1;
                    end
                end
                ST_FORCE: begin
                    w_state_next  = ST_WAIT;
                    w_starve_next = '0;
                end
                default: begin
                    w_state_next  = ST_IDLE;
                    w_starve_next = '0;
                end
            endcase
        end
    end

    // Starvation outputs: stall exactly during the forced-drain cycle.
    always_comb begin
        pipe_stall = (r_state == ST_FORCE);
        dbg_state  = r_state;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: queue-based behavioural model checked
// on every cycle, plus hand-computed literal checks per scenario.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 8;
  localparam int AW           = 5;
  localparam int DW           = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          wb_regwrite;
  logic [AW-1:0] wb_writereg;
  logic [DW-1:0] wb_writedata;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_writereg;
  logic [DW-1:0] mdu_writedata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          pipe_stall;
  logic [AW-1:0] chk_reg;
  logic          chk_pending;
  arb_state_t    dbg_state;

  rf_write_arbiter #(
    .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_writereg(mdu_writereg), .mdu_writedata(mdu_writedata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .chk_reg(chk_reg), .chk_pending(chk_pending),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Buffer is a queue of pending results; 'live' drops when a younger
  // write-back hits the same register. head_age counts consecutive cycles
  // the current head sat un-popped; reaching the limit makes the next cycle
  // a stall cycle in which write-back is ignored.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            live;
  } ent_t;

  ent_t          exp_q[$];
  bit            m_force;
  int            m_age;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_wb_eff, m_was_empty, m_removed, m_ready;
  ent_t          m_ent;

  function automatic bit m_pending(logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i].live && exp_q[i].addr == r) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_force = 1'b0; m_age = 0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      m_wb_eff    = wb_regwrite && (wb_writereg != 0) && !m_force;
      m_ready     = exp_q.size() < DEPTH;
      m_was_empty = exp_q.size() == 0;
      m_removed   = 1'b0;
      m_we        = 1'b0;
      if (m_wb_eff) begin
        m_we = 1'b1; m_waddr = wb_writereg; m_wdata = wb_writedata;
      end
      if (exp_q.size() > 0) begin
        if (!exp_q[0].live) begin
          void'(exp_q.pop_front());
          m_removed = 1'b1;
        end else if (!m_wb_eff) begin
          m_we = 1'b1; m_waddr = exp_q[0].addr; m_wdata = exp_q[0].data;
          void'(exp_q.pop_front());
          m_removed = 1'b1;
        end
      end
      if (m_wb_eff) foreach (exp_q[i]) if (exp_q[i].addr == wb_writereg) exp_q[i].live = 1'b0;
      if (mdu_valid && m_ready && mdu_writereg != 0) begin
        m_ent.addr = mdu_writereg; m_ent.data = mdu_writedata; m_ent.live = 1'b1;
        exp_q.push_back(m_ent);
      end
      if (exp_q.size() == 0) begin
        m_force = 1'b0; m_age = 0;
      end else if (m_force || m_was_empty || m_removed) begin
        m_force = 1'b0; m_age = 0;
      end else begin
        m_age++;
        if (m_age == STARVE_LIMIT) begin
          m_force = 1'b1; m_age = 0;
        end
      end
    end
  end

  // Compare process: every cycle out of reset, mid-cycle.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("m_rf_we", 32'(rf_we), 32'(m_we));
      if (m_we) begin
        check("m_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        check("m_rf_wdata", rf_wdata, m_wdata);
      end
      check("m_mdu_ready", 32'(mdu_ready), 32'(exp_q.size() < DEPTH));
      check("m_pipe_stall", 32'(pipe_stall), 32'(m_force));
      check("m_chk_pending", 32'(chk_pending), 32'(m_pending(chk_reg)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input bit en, input logic [AW-1:0] r, input logic [DW-1:0] d);
    wb_regwrite = en; wb_writereg = r; wb_writedata = d;
  endtask

  task automatic drive_mdu(input bit v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    mdu_valid = v; mdu_writereg = r; mdu_writedata = d;
  endtask

  // Watchdog: the stimulus is straight-line, but never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    drive_wb(0, 0, 0);
    drive_mdu(0, 0, 0);
    chk_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_rf_we", 32'(rf_we), 0);
    check("rst_rf_waddr", 32'(rf_waddr), 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_mdu_ready", 32'(mdu_ready), 1);
    check("rst_pipe_stall", 32'(pipe_stall), 0);
    step();
    check("idle_rf_we", 32'(rf_we), 0);

    // A: single MDU result in idle slots, written two edges after the push.
    drive_mdu(1, 5'd5, 32'h1234);
    step();
    drive_mdu(0, 0, 0);
    check("a_we_pending", 32'(rf_we), 0);
    step();
    check("a_we", 32'(rf_we), 1);
    check("a_waddr", 32'(rf_waddr), 5);
    check("a_wdata", rf_wdata, 32'h1234);
    step();
    check("a_we_done", 32'(rf_we), 0);

    // B: write-back to r7 every cycle starves r6 until the forced drain.
    drive_wb(1, 5'd7, 32'h77);
    drive_mdu(1, 5'd6, 32'hAA);
    step();
    drive_mdu(0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      check("b_no_stall", 32'(pipe_stall), 0);
      step();
    end
    check("b_stall", 32'(pipe_stall), 1);
    check("b_state_force", 32'(dbg_state), 32'(ST_FORCE));
    step();
    check("b_r6_waddr", 32'(rf_waddr), 6);
    check("b_r6_wdata", rf_wdata, 32'hAA);
    check("b_stall_off", 32'(pipe_stall), 0);
    step();
    check("b_wb_resume", 32'(rf_waddr), 7);
    drive_wb(0, 0, 0);
    step();

    // C: fill the buffer behind busy write-back; third result waits.
    drive_wb(1, 5'd7, 32'h77);
    drive_mdu(1, 5'd8, 32'h8);
    step();
    drive_mdu(1, 5'd9, 32'h9);
    step();
    drive_mdu(1, 5'd11, 32'hB);
    check("c_full", 32'(mdu_ready), 0);
    step();
    check("c_held", 32'(mdu_ready), 0);
    drive_wb(0, 0, 0);
    check("c_no_bypass", 32'(mdu_ready), 0);
    step();
    check("c_ready_after_pop", 32'(mdu_ready), 1);
    check("c_r8", 32'(rf_waddr), 8);
    step();
    drive_mdu(0, 0, 0);
    check("c_r9", 32'(rf_waddr), 9);
    step();
    check("c_r11", 32'(rf_waddr), 11);
    check("c_r11_data", rf_wdata, 32'hB);
    step();
    check("c_drained", 32'(rf_we), 0);

    // D: younger write-back to r10 cancels the buffered r10 result.
    drive_wb(1, 5'd7, 32'h77);
    drive_mdu(1, 5'd10, 32'h1);
    chk_reg = 5'd10;
    check("d_pend_before", 32'(chk_pending), 0);
    step();
    drive_mdu(0, 0, 0);
    drive_wb(1, 5'd10, 32'h2);
    check("d_pend_buffered", 32'(chk_pending), 1);
    step();
    drive_wb(0, 0, 0);
    check("d_pend_killed", 32'(chk_pending), 0);
    check("d_r10_waddr", 32'(rf_waddr), 10);
    check("d_r10_wdata", rf_wdata, 32'h2);
    step();
    check("d_killed_not_written", 32'(rf_we), 0);
    check("d_ready", 32'(mdu_ready), 1);
    chk_reg = '0;

    // E: r0 from either source is a no-op; an r0 write-back slot drains.
    drive_wb(1, 5'd0, 32'h66);
    drive_mdu(1, 5'd0, 32'h55);
    step();
    drive_wb(0, 0, 0);
    drive_mdu(0, 0, 0);
    check("e_r0_no_we", 32'(rf_we), 0);
    step();
    check("e_r0_dropped", 32'(rf_we), 0);
    drive_wb(1, 5'd7, 32'h77);
    drive_mdu(1, 5'd12, 32'hC);
    step();
    drive_mdu(0, 0, 0);
    drive_wb(1, 5'd0, 32'h66);
    step();
    drive_wb(0, 0, 0);
    check("e_drain_we", 32'(rf_we), 1);
    check("e_drain_waddr", 32'(rf_waddr), 12);
    check("e_drain_wdata", rf_wdata, 32'hC);
    step();

    // F: reset mid-drain discards the remaining buffered result.
    drive_wb(1, 5'd7, 32'h77);
    drive_mdu(1, 5'd13, 32'hD);
    step();
    drive_mdu(1, 5'd14, 32'hE);
    step();
    drive_mdu(0, 0, 0);
    drive_wb(0, 0, 0);
    step();
    check("f_r13", 32'(rf_waddr), 13);
    #2;
    reset = 1'b1;
    #1;
    check("f_rst_we", 32'(rf_we), 0);
    check("f_rst_ready", 32'(mdu_ready), 1);
    check("f_rst_stall", 32'(pipe_stall), 0);
    #3;
    reset = 1'b0;
    chk_reg = 5'd14;
    #1;
    check("f_pend_cleared", 32'(chk_pending), 0);
    step();
    check("f_no_r14", 32'(rf_we), 0);
    step();
    check("f_still_idle", 32'(rf_we), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single register-file write port between the pipeline write-back path and a multi-cycle multiply/divide unit (MDU).
- Pipeline write-back always has priority.
- MDU results are held in a small buffer and drained into idle write-back slots.
- When a buffered result waits too long, the block stalls the pipeline for one cycle to force a drain.
- Sits between the write-back stage / MDU and the register file; also reports pending destinations to the hazard unit.

Parameters:
DEPTH, 2, MDU result buffer entries (power of two, 2..4)
STARVE_LIMIT, 8, cycles the oldest buffered entry may wait before a forced drain
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wb_regwrite  in  1  pipeline write-back write enable
wb_writereg  in  AW  pipeline write-back destination
wb_writedata  in  DW  pipeline write-back data
mdu_valid  in  1  MDU result offered
mdu_ready  out  1  buffer can accept an MDU result
mdu_writereg  in  AW  MDU destination
mdu_writedata  in  DW  MDU result
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  AW  register-file write address (registered)
rf_wdata  out  DW  register-file write data (registered)
pipe_stall  out  1  freezes IF..MEM and suppresses wb_regwrite for the next cycle
chk_reg  in  AW  source register queried by the hazard unit
chk_pending  out  1  chk_reg matches a valid buffered destination

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0. Buffer empty, starve counter 0, mdu_ready=1.
- Reset asserted mid-operation discards all buffered results.
- Effective pipeline write: wb_regwrite=1 and wb_writereg!=0. Writes to r0 count as idle slots.
- Port selection, evaluated each cycle:
  1. Effective pipeline write -> rf_* take wb values next cycle.
  2. Else, if the buffer is non-empty -> pop the oldest entry into rf_*.
  3. Else -> rf_we=0.
- Write latency: exactly 1 cycle, for both sources.
- MDU handshake:
  - Transfer occurs when mdu_valid & mdu_ready at the rising edge.
  - mdu_ready = !full, combinational from state.
  - MDU results with mdu_writereg=0 are accepted and dropped.
- Full/empty:
  - When full, mdu_ready=0.
  - A pop and a push in the same cycle when full: mdu_ready stays 0 (no bypass).
  - Push into an empty buffer during an idle slot does not write the same cycle. The earliest write is 1 cycle after acceptance (entry popped next cycle, rf_we the cycle after).
- Ordering:
  - FIFO order, with wrapping read/write pointers.
  - Count width is log2(DEPTH)+1.
- WAW kill:
  - An effective pipeline write whose wb_writereg matches a valid buffered destination invalidates that entry (the pipeline write is younger).
  - Invalidated entries are skipped at pop without consuming a write slot.
  - Occupancy is freed on the skip.
- Starvation state machine (IDLE, WAIT, FORCE):
  - IDLE: buffer empty. Goes to WAIT when an entry is pushed.
  - WAIT: counter increments each cycle the head is not popped; resets to 0 on a pop. Counter reaching STARVE_LIMIT-1 -> FORCE.
  - FORCE: pipe_stall=1 for exactly one cycle. That slot is guaranteed idle and the head is popped.
  - After FORCE: WAIT if entries remain, else IDLE. The counter is cleared.
  - Buffer becoming empty in any state -> IDLE.
- chk_pending is combinational: OR over valid entries of (dest==chk_reg), forced 0 when chk_reg==0.

Decomposition:
- Shared package: AW/DW constants, the r0 constant, and the arbiter state enum (IDLE/WAIT/FORCE).
- One sub-module is natural: mdu_result_fifo, a DEPTH-entry FIFO with per-entry valid bits, a kill-by-address port and a dest-match output. The arbiter top holds the selection, output registers and starvation FSM.

Test Plan:
- Reset, then idle -> rf_we=0, mdu_ready=1, pipe_stall=0. Assert reset mid-drain with 2 entries buffered -> buffer empty, rf_we=0 immediately.
- MDU pushes (r5, 0x1234) with wb_regwrite=0 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 two cycles after the push.
- Buffer (r6, 0xAA) and hold wb_regwrite=1 to r7 continuously -> pipe_stall=1 for one cycle after 8 waiting cycles; r6 written the next cycle; wb writes to r7 resume.
- Push 2 entries (r8, r9) with WB busy -> mdu_ready=0. Third mdu_valid is held off until the first pop, then accepted.
- Buffer (r10, 0x1) and WB writes r10=0x2 -> r10 ends at 0x2, buffered entry never written, chk_reg=10 -> chk_pending goes 1 then 0.
- MDU result to r0 and WB write to r0 -> no rf_we from either; a buffered entry drains in the r0 WB slot.
